muldiv_unit: RTL and testbench

- HI/LO multiply/divide unit in the EX stage of the 5-stage pipeline. It executes MULT/MULTU/DIV/DIVU/MTHI/MTLO as selected by the decoder's MULDIVMode, and serves MFHI/MFLO reads through HILOSel.
- It produces the Start/Busy pair that the hazard controller uses to stall any ID-stage mult/div-class instruction while an operation is in flight.

---
 rtl/muldiv_unit_pkg.sv | 33 +++
 rtl/muldiv_arith.sv | 58 +++++
 rtl/muldiv_unit.sv | 98 +++++++++
 tb/tb_muldiv_unit.sv | 212 +++++++++++++++++++++
 4 files changed

// File: rtl/muldiv_unit_pkg.sv
// Shared encodings and defaults for the HI/LO multiply/divide unit.
package muldiv_unit_pkg;

   localparam logic [3:0] MULDIVMODE_NOTHING = 4'd0;
   localparam logic [3:0] MULDIVMODE_MULT    = 4'd1;
   localparam logic [3:0] MULDIVMODE_MULTU   = 4'd2;
   localparam logic [3:0] MULDIVMODE_DIV     = 4'd3;
   localparam logic [3:0] MULDIVMODE_DIVU    = 4'd4;
   localparam logic [3:0] MULDIVMODE_MTHI    = 4'd5;
   localparam logic [3:0] MULDIVMODE_MTLO    = 4'd6;

   localparam logic MULDIV_HIGH = 1'b1;
   localparam logic MULDIV_LOW  = 1'b0;

   localparam int unsigned MULT_CYCLES_DEF = 32'd5;
   localparam int unsigned DIV_CYCLES_DEF  = 32'd10;

   function automatic logic is_long_op(input logic [3:0] mode);
      case (mode)
         MULDIVMODE_MULT, MULDIVMODE_MULTU,
         MULDIVMODE_DIV,  MULDIVMODE_DIVU:  is_long_op = 1'b1;
         default:                           is_long_op = 1'b0;
      endcase
   endfunction

   function automatic logic is_div_op(input logic [3:0] mode);
      case (mode)
         MULDIVMODE_DIV, MULDIVMODE_DIVU: is_div_op = 1'b1;
         default:                         is_div_op = 1'b0;
      endcase
   endfunction

endpackage

// File: rtl/muldiv_arith.sv
// Combinational 64-bit multiply and 32-bit divide for the HI/LO unit.
module muldiv_arith
   import muldiv_unit_pkg::*;
(
   input  logic [3:0]  MULDIVMode,
   input  logic [31:0] A,
   input  logic [31:0] B,
   output logic [31:0] res_hi,
   output logic [31:0] res_lo,
   output logic        div_by_zero
);

   logic [63:0] w_sprod;
   logic [63:0] w_uprod;
   logic        w_signed_div;
   logic [31:0] w_mag_a;
   logic [31:0] w_mag_b;
   logic [31:0] w_divisor;
   logic [31:0] w_uquot;
   logic [31:0] w_urem;
   logic        w_quot_neg;

   assign w_sprod = {{32{A[31]}}, A} * {{32{B[31]}}, B};
   assign w_uprod = {32'd0, A} * {32'd0, B};

   // One unsigned divider serves both DIV and DIVU; signed divide works on
   // magnitudes, so 0x80000000 / -1 naturally yields 0x80000000 rem 0.
   assign w_signed_div = (MULDIVMode == MULDIVMODE_DIV);
   assign w_mag_a      = (w_signed_div && A[31]) ? (32'd0 - A) : A;
   assign w_mag_b      = (w_signed_div && B[31]) ? (32'd0 - B) : B;
   assign div_by_zero  = (B == 32'd0);
   assign w_divisor    = div_by_zero ? 32'd1 : w_mag_b;
   assign w_uquot      = w_mag_a / w_divisor;
   assign w_urem       = w_mag_a % w_divisor;
   assign w_quot_neg   = A[31] ^ B[31];

   always_comb begin
      res_hi = 32'd0;
      res_lo = 32'd0;
      case (MULDIVMode)
         MULDIVMODE_MULT:  {res_hi, res_lo} = w_sprod;
         MULDIVMODE_MULTU: {res_hi, res_lo} = w_uprod;
         MULDIVMODE_DIV: begin
            res_lo = w_quot_neg ? (32'd0 - w_uquot) : w_uquot;
            res_hi = A[31] ? (32'd0 - w_urem) : w_urem;
         end
         MULDIVMODE_DIVU: begin
            res_lo = w_uquot;
            res_hi = w_urem;
         end
         default: begin
            res_hi = 32'd0;
            res_lo = 32'd0;
         end
      endcase
   end

endmodule

// File: rtl/muldiv_unit.sv
// EX-stage HI/LO unit: latches a mult/div result at Start, holds Busy for a
// fixed cycle count, then commits the result into the architectural HI/LO.
module muldiv_unit
   import muldiv_unit_pkg::*;
#(
   parameter int unsigned MULT_CYCLES = MULT_CYCLES_DEF,
   parameter int unsigned DIV_CYCLES  = DIV_CYCLES_DEF
)(
   input  logic        clk,
   input  logic        reset,
   input  logic [3:0]  MULDIVMode,
   input  logic        HILOSel,
   input  logic [31:0] A,
   input  logic [31:0] B,
   output logic        Start,
   output logic        Busy,
   output logic [31:0] MULDIVOut
);

   localparam int unsigned MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
   localparam int unsigned CNT_W      = $clog2(MAX_CYCLES + 1);

   localparam logic [0:0] ST_IDLE = 1'b0;
   localparam logic [0:0] ST_RUN  = 1'b1;

   logic [0:0]       r_state;
   logic [CNT_W-1:0] r_cnt;
   logic [31:0]      r_hi;
   logic [31:0]      r_lo;
   logic [31:0]      r_pend_hi;
   logic [31:0]      r_pend_lo;
   logic             r_pend_skip;

   logic [31:0]      w_res_hi;
   logic [31:0]      w_res_lo;
   logic             w_div_by_zero;
   logic             w_start;

   muldiv_arith u_arith (
      .MULDIVMode  (MULDIVMode),
      .A           (A),
      .B           (B),
      .res_hi      (w_res_hi),
      .res_lo      (w_res_lo),
      .div_by_zero (w_div_by_zero)
   );

   assign w_start   = is_long_op(MULDIVMode) && (r_state == ST_IDLE);
   assign Start     = w_start;
   assign Busy      = (r_state == ST_RUN);
   assign MULDIVOut = (HILOSel == MULDIV_HIGH) ? r_hi : r_lo;

   always_ff @(posedge clk) begin
      if (reset) begin
         r_state     <= ST_IDLE;
         r_cnt       <= '0;
         r_hi        <= 32'd0;
         r_lo        <= 32'd0;
         r_pend_hi   <= 32'd0;
         r_pend_lo   <= 32'd0;
         r_pend_skip <= 1'b0;
      end else begin
         case (r_state)
            ST_IDLE: begin
               if (w_start) begin
                  r_pend_hi   <= w_res_hi;
                  r_pend_lo   <= w_res_lo;
                  // A zero divisor still occupies the unit but must not touch HI/LO.
                  r_pend_skip <= is_div_op(MULDIVMode) && w_div_by_zero;
                  r_cnt       <= is_div_op(MULDIVMode) ? CNT_W'(DIV_CYCLES) : CNT_W'(MULT_CYCLES);
                  r_state     <= ST_RUN;
               end else if (MULDIVMode == MULDIVMODE_MTHI) begin
                  r_hi <= A;
               end else if (MULDIVMode == MULDIVMODE_MTLO) begin
                  r_lo <= A;
               end
            end
            ST_RUN: begin
               if (r_cnt == CNT_W'(1)) begin
                  if (!r_pend_skip) begin
                     r_hi <= r_pend_hi;
                     r_lo <= r_pend_lo;
                  end
                  r_cnt   <= '0;
                  r_state <= ST_IDLE;
               end else begin
                  r_cnt <= r_cnt - CNT_W'(1);
               end
            end
            default: begin
               r_state <= ST_IDLE;
               r_cnt   <= '0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_muldiv_unit.sv
// Directed and randomized check of muldiv_unit against a cycle-level
// behavioural model built from plain 64-bit integer arithmetic.
module tb_muldiv_unit;
   import muldiv_unit_pkg::*;

   localparam int N_MULT = 5;
   localparam int N_DIV  = 10;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic [3:0]  MULDIVMode = 4'd0;
   logic        HILOSel = 1'b0;
   logic [31:0] A = 32'd0;
   logic [31:0] B = 32'd0;
   logic        Start;
   logic        Busy;
   logic [31:0] MULDIVOut;

   int n_cmp = 0;
   int n_err = 0;

   logic [31:0] m_hi = 32'd0;
   logic [31:0] m_lo = 32'd0;
   logic [31:0] m_pend_hi = 32'd0;
   logic [31:0] m_pend_lo = 32'd0;
   bit          m_pend_skip = 1'b0;
   bit          m_pending = 1'b0;
   int          m_done_cyc = 0;
   int          cyc = 0;

   muldiv_unit dut (
      .clk        (clk),
      .reset      (reset),
      .MULDIVMode (MULDIVMode),
      .HILOSel    (HILOSel),
      .A          (A),
      .B          (B),
      .Start      (Start),
      .Busy       (Busy),
      .MULDIVOut  (MULDIVOut)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h (cycle %0d)", tag, got, exp, cyc);
      end
   endtask

   function automatic void ref_op(input logic [3:0] mode, input logic [31:0] a, input logic [31:0] b,
                                  output logic [31:0] hi, output logic [31:0] lo, output bit skip);
      longint          sa, sb, sp, sq, sr;
      longint unsigned ua, ub, up, uq, ur;
      sa = longint'($signed(a));
      sb = longint'($signed(b));
      ua = {32'd0, a};
      ub = {32'd0, b};
      hi = 32'd0;
      lo = 32'd0;
      skip = 1'b0;
      case (mode)
         MULDIVMODE_MULT:  begin sp = sa * sb; hi = sp[63:32]; lo = sp[31:0]; end
         MULDIVMODE_MULTU: begin up = ua * ub; hi = up[63:32]; lo = up[31:0]; end
         MULDIVMODE_DIV: begin
            if (b == 32'd0) skip = 1'b1;
            else begin sq = sa / sb; sr = sa % sb; lo = sq[31:0]; hi = sr[31:0]; end
         end
         MULDIVMODE_DIVU: begin
            if (b == 32'd0) skip = 1'b1;
            else begin uq = ua / ub; ur = ua % ub; lo = uq[31:0]; hi = ur[31:0]; end
         end
         default: skip = 1'b1;
      endcase
   endfunction

   // One clock cycle: drive inputs, compare outputs with the model, then advance the model.
   task automatic cycle(input logic rst, input logic [3:0] mode, input logic sel,
                        input logic [31:0] a, input logic [31:0] b);
      bit long_op;
      @(posedge clk);
      #1;
      reset = rst; MULDIVMode = mode; HILOSel = sel; A = a; B = b;
      #1;
      long_op = (mode >= MULDIVMODE_MULT) && (mode <= MULDIVMODE_DIVU);
      check("out", MULDIVOut, sel ? m_hi : m_lo);
      check("busy", {31'd0, Busy}, {31'd0, m_pending});
      check("start", {31'd0, Start}, {31'd0, long_op && !m_pending});
      if (rst) begin
         m_hi = 32'd0; m_lo = 32'd0; m_pend_hi = 32'd0; m_pend_lo = 32'd0;
         m_pend_skip = 1'b0; m_pending = 1'b0;
      end else if (m_pending) begin
         if (cyc == m_done_cyc) begin
            if (!m_pend_skip) begin m_hi = m_pend_hi; m_lo = m_pend_lo; end
            m_pending = 1'b0;
         end
      end else if (long_op) begin
         ref_op(mode, a, b, m_pend_hi, m_pend_lo, m_pend_skip);
         m_pending  = 1'b1;
         m_done_cyc = cyc + ((mode >= MULDIVMODE_DIV) ? N_DIV : N_MULT);
      end else if (mode == MULDIVMODE_MTHI) begin
         m_hi = a;
      end else if (mode == MULDIVMODE_MTLO) begin
         m_lo = a;
      end
      cyc++;
   endtask

   task automatic busy_run(input int n, input string tag);
      for (int i = 0; i < n; i++) begin
         cycle(1'b0, MULDIVMODE_NOTHING, MULDIV_LOW, 32'd0, 32'd0);
         check(tag, {31'd0, Busy}, 32'd1);
      end
   endtask

   function automatic logic [31:0] pick_val();
      logic [31:0] specials [6];
      specials = '{32'h0000_0000, 32'h0000_0001, 32'hFFFF_FFFF, 32'h8000_0000, 32'h7FFF_FFFF, 32'h0000_0002};
      if ($urandom_range(0, 3) == 0) return specials[$urandom_range(0, 5)];
      return $urandom;
   endfunction

   initial begin
      cycle(1'b1, MULDIVMODE_NOTHING, MULDIV_LOW, 32'd0, 32'd0);
      cycle(1'b1, MULDIVMODE_NOTHING, MULDIV_LOW, 32'd0, 32'd0);
      cycle(1'b0, MULDIVMODE_NOTHING, MULDIV_LOW, 32'd0, 32'd0);
      check("rst_lo", MULDIVOut, 32'h0);
      cycle(1'b0, MULDIVMODE_NOTHING, MULDIV_HIGH, 32'd0, 32'd0);
      check("rst_hi", MULDIVOut, 32'h0);
      check("rst_busy", {31'd0, Busy}, 32'd0);
      check("rst_start", {31'd0, Start}, 32'd0);

      cycle(1'b0, MULDIVMODE_MULT, MULDIV_LOW, 32'd3, 32'hFFFF_FFFE);
      check("mult_start", {31'd0, Start}, 32'd1);
      busy_run(N_MULT, "mult_busy");
      cycle(1'b0, MULDIVMODE_NOTHING, MULDIV_HIGH, 32'd0, 32'd0);
      check("mult_idle", {31'd0, Busy}, 32'd0);
      check("mult_hi", MULDIVOut, 32'hFFFF_FFFF);
      cycle(1'b0, MULDIVMODE_NOTHING, MULDIV_LOW, 32'd0, 32'd0);
      check("mult_lo", MULDIVOut, 32'hFFFF_FFFA);

      cycle(1'b0, MULDIVMODE_MULTU, MULDIV_LOW, 32'hFFFF_FFFF, 32'd2);
      busy_run(N_MULT, "multu_busy");
      cycle(1'b0, MULDIVMODE_NOTHING, MULDIV_HIGH, 32'd0, 32'd0);
      check("multu_hi", MULDIVOut, 32'h0000_0001);
      cycle(1'b0, MULDIVMODE_NOTHING, MULDIV_LOW, 32'd0, 32'd0);
      check("multu_lo", MULDIVOut, 32'hFFFF_FFFE);

      cycle(1'b0, MULDIVMODE_DIV, MULDIV_LOW, 32'hFFFF_FFF9, 32'd2);
      busy_run(N_DIV, "div_busy");
      cycle(1'b0, MULDIVMODE_NOTHING, MULDIV_HIGH, 32'd0, 32'd0);
      check("div_hi", MULDIVOut, 32'hFFFF_FFFF);
      cycle(1'b0, MULDIVMODE_NOTHING, MULDIV_LOW, 32'd0, 32'd0);
      check("div_lo", MULDIVOut, 32'hFFFF_FFFD);

      cycle(1'b0, MULDIVMODE_MTHI, MULDIV_LOW, 32'h11, 32'd0);
      cycle(1'b0, MULDIVMODE_DIVU, MULDIV_HIGH, 32'd7, 32'd0);
      busy_run(N_DIV, "dbz_busy");
      cycle(1'b0, MULDIVMODE_NOTHING, MULDIV_HIGH, 32'd0, 32'd0);
      check("dbz_idle", {31'd0, Busy}, 32'd0);
      check("dbz_hi", MULDIVOut, 32'h11);
      cycle(1'b0, MULDIVMODE_NOTHING, MULDIV_LOW, 32'd0, 32'd0);
      check("dbz_lo", MULDIVOut, 32'hFFFF_FFFD);

      cycle(1'b0, MULDIVMODE_DIV, MULDIV_LOW, 32'd100, 32'd7);
      cycle(1'b0, MULDIVMODE_NOTHING, MULDIV_LOW, 32'd0, 32'd0);
      cycle(1'b0, MULDIVMODE_MTHI, MULDIV_HIGH, 32'h1234, 32'd0);
      check("mthi_busy_start", {31'd0, Start}, 32'd0);
      busy_run(N_DIV - 2, "mthi_busy");
      cycle(1'b0, MULDIVMODE_NOTHING, MULDIV_HIGH, 32'd0, 32'd0);
      check("mthi_ign_hi", MULDIVOut, 32'd2);
      cycle(1'b0, MULDIVMODE_NOTHING, MULDIV_LOW, 32'd0, 32'd0);
      check("mthi_ign_lo", MULDIVOut, 32'd14);

      cycle(1'b0, MULDIVMODE_MTLO, MULDIV_LOW, 32'hABCD, 32'd0);
      cycle(1'b0, MULDIVMODE_NOTHING, MULDIV_LOW, 32'd0, 32'd0);
      check("mtlo_lo", MULDIVOut, 32'hABCD);

      cycle(1'b0, MULDIVMODE_DIV, MULDIV_LOW, 32'h8000_0000, 32'hFFFF_FFFF);
      busy_run(N_DIV, "ovf_busy");
      cycle(1'b0, MULDIVMODE_NOTHING, MULDIV_LOW, 32'd0, 32'd0);
      check("ovf_lo", MULDIVOut, 32'h8000_0000);
      cycle(1'b0, MULDIVMODE_NOTHING, MULDIV_HIGH, 32'd0, 32'd0);
      check("ovf_hi", MULDIVOut, 32'h0);

      cycle(1'b0, MULDIVMODE_MTHI, MULDIV_LOW, 32'h55, 32'd0);
      cycle(1'b0, MULDIVMODE_MTLO, MULDIV_LOW, 32'h66, 32'd0);
      cycle(1'b0, MULDIVMODE_MULT, MULDIV_LOW, 32'd3, 32'd4);
      busy_run(2, "rmid_busy");
      cycle(1'b1, MULDIVMODE_NOTHING, MULDIV_LOW, 32'd0, 32'd0);
      cycle(1'b0, MULDIVMODE_NOTHING, MULDIV_HIGH, 32'd0, 32'd0);
      check("rmid_busy0", {31'd0, Busy}, 32'd0);
      check("rmid_hi", MULDIVOut, 32'h0);
      for (int i = 0; i < N_MULT + 2; i++)
         cycle(1'b0, MULDIVMODE_NOTHING, MULDIV_LOW, 32'd0, 32'd0);
      check("rmid_lo", MULDIVOut, 32'h0);

      for (int i = 0; i < 3000; i++) begin
         logic [3:0]  mode;
         logic [31:0] bv;
         mode = ($urandom_range(0, 9) < 8) ? 4'($urandom_range(0, 6)) : 4'($urandom_range(7, 15));
         bv   = ($urandom_range(0, 15) == 0) ? 32'd0 : pick_val();
         cycle(($urandom_range(0, 199) == 0) ? 1'b1 : 1'b0, mode, 1'($urandom_range(0, 1)), pick_val(), bv);
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
